// File: rtl/jb_dl_dfe_ctrl_shadow.sv
// Shadowed DFE carrier/antenna control; a commit applies the shadow set 2 clocks after the slot sync_pulse.
// No backpressure: writes land every cycle; JB_DL_DFE_GAIN_RAMP_EN enables rate-limited gain ramping.
module jb_dl_dfe_ctrl_shadow #(
    parameter int          N_CAR     = 2,
    parameter int          N_ANT     = 4,
    parameter logic [15:0] RAMP_STEP = 16'h0100
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [7:0]                         wr_addr,
    input  logic [31:0]                        wr_data,
    input  logic                               commit_req,
    input  logic                               sync_pulse,
    input  logic                               clr_flags,
    output logic                               busy,
    output logic                               commit_ack,
    output logic                               commit_overrun,
    output logic [N_CAR-1:0][31:0]             car_nco_lsb,
    output logic [N_CAR-1:0][6:0]              car_nco_msb,
    output logic [N_CAR-1:0]                   car_nco_sign,
    output logic [N_CAR-1:0][N_ANT-1:0][15:0]  stream_gain_fraction,
    output logic [N_ANT-1:0][5:0]              ant_delay,
    output logic                               bypass_dpd,
    output logic                               bypass_cfr,
    output logic                               int_frac_delay_trig
);

    typedef enum logic [1:0] {IDLE, ARMED, APPLY, RAMP} state_t;
    state_t state_q, state_d;

    logic [N_CAR-1:0][31:0]            lsb_sh_q, lsb_q;
    logic [N_CAR-1:0][6:0]             msb_sh_q, msb_q;
    logic [N_CAR-1:0]                  sign_sh_q, sign_q;
    logic [N_CAR-1:0][N_ANT-1:0][15:0] gain_sh_q, gain_q;
    logic [N_ANT-1:0][5:0]             dly_sh_q, dly_q;
    logic [1:0]                        byp_sh_q, byp_q;
    logic                              busy_q, ack_q, trig_q, ovr_q;
    logic                              ack_d, ovr_d;

    function automatic logic [15:0] step_toward(input logic [15:0] cur, input logic [15:0] tgt);
        logic [15:0] diff;
        if (tgt >= cur) begin
            diff = tgt - cur;
            return (diff > RAMP_STEP) ? cur + RAMP_STEP : tgt;
        end
        diff = cur - tgt;
        return (diff > RAMP_STEP) ? cur - RAMP_STEP : tgt;
    endfunction

    // Out-of-range carrier/antenna indices and unmapped addresses match nothing below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsb_sh_q  <= '0;
            msb_sh_q  <= '0;
            sign_sh_q <= '0;
            gain_sh_q <= '0;
            dly_sh_q  <= '0;
            byp_sh_q  <= '0;
        end else if (wr_en) begin
            for (int c = 0; c < N_CAR; c++) begin
                if (wr_addr == 8'(c))
                    lsb_sh_q[c] <= wr_data;
                if (wr_addr == 8'(16 + c)) begin
                    msb_sh_q[c]  <= wr_data[6:0];
                    sign_sh_q[c] <= wr_data[7];
                end
                for (int a = 0; a < N_ANT; a++)
                    if (wr_addr == 8'(64 + 16 * c + a))
                        gain_sh_q[c][a] <= wr_data[15:0];
            end
            for (int a = 0; a < N_ANT; a++)
                if (wr_addr == 8'(128 + a))
                    dly_sh_q[a] <= wr_data[5:0];
            if (wr_addr == 8'h20)
                byp_sh_q <= wr_data[1:0];
        end
    end

`ifdef JB_DL_DFE_GAIN_RAMP_EN
    logic [N_CAR-1:0][N_ANT-1:0][15:0] gain_tgt_q, gain_ramp_d;
    logic                              gains_eq;

    always_comb begin
        gain_ramp_d = gain_q;
        for (int c = 0; c < N_CAR; c++)
            for (int a = 0; a < N_ANT; a++)
                gain_ramp_d[c][a] = step_toward(gain_q[c][a], gain_tgt_q[c][a]);
    end

    assign gains_eq = (gain_q == gain_tgt_q);
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE:  if (commit_req) state_d = ARMED;
            ARMED: if (sync_pulse) state_d = APPLY;
`ifdef JB_DL_DFE_GAIN_RAMP_EN
            APPLY: state_d = RAMP;
            RAMP: begin
                if (gains_eq) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end
            end
`else
            APPLY: begin
                state_d = IDLE;
                ack_d   = 1'b1;
            end
            RAMP:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Set has priority over clear so a rejected request is never lost.
    assign ovr_d = (commit_req && (state_q != IDLE)) || (ovr_q && !clr_flags);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            trig_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            ack_q   <= ack_d;
            trig_q  <= (state_d == APPLY);
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsb_q  <= '0;
            msb_q  <= '0;
            sign_q <= '0;
            gain_q <= '0;
            dly_q  <= '0;
            byp_q  <= '0;
`ifdef JB_DL_DFE_GAIN_RAMP_EN
            gain_tgt_q <= '0;
`endif
        end else if (state_q == APPLY) begin
            lsb_q  <= lsb_sh_q;
            msb_q  <= msb_sh_q;
            sign_q <= sign_sh_q;
            dly_q  <= dly_sh_q;
            byp_q  <= byp_sh_q;
`ifdef JB_DL_DFE_GAIN_RAMP_EN
            gain_tgt_q <= gain_sh_q;
        end else if (state_q == RAMP) begin
            gain_q <= gain_ramp_d;
`else
            gain_q <= gain_sh_q;
`endif
        end
    end

    assign busy                 = busy_q;
    assign commit_ack           = ack_q;
    assign commit_overrun       = ovr_q;
    assign int_frac_delay_trig  = trig_q;
    assign car_nco_lsb          = lsb_q;
    assign car_nco_msb          = msb_q;
    assign car_nco_sign         = sign_q;
    assign stream_gain_fraction = gain_q;
    assign ant_delay            = dly_q;
    assign bypass_cfr           = byp_q[1];
    assign bypass_dpd           = byp_q[0];

endmodule

// File: doc/jb_dl_dfe_ctrl_shadow.md
JB_DL_DFE_CTRL_SHADOW -- requirements
Module: jb_dl_dfe_ctrl_shadow

Interface
REQ-001 SHALL have parameter N_CAR, default 2, carrier count, legal 1..4.
REQ-002 SHALL have parameter N_ANT, default 4, antenna count, legal 1..16.
REQ-003 SHALL have parameter RAMP_STEP, default 16'h0100, maximum gain change per clock.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic rising-edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: wr_en  in  1  shadow write strobe; wr_addr  in  8  register address; wr_data  in  32  write data.
REQ-006 SHALL have ports: commit_req  in  1  one-cycle request to apply the shadow set; sync_pulse  in  1  slot-boundary strobe; clr_flags  in  1  clears sticky flags.
REQ-007 SHALL have ports: busy  out  1  commit in progress; commit_ack  out  1  one-cycle commit-done pulse; commit_overrun  out  1  sticky rejected-request flag.
REQ-008 SHALL have ports: car_nco_lsb  out  N_CAR x 32; car_nco_msb  out  N_CAR x 7; car_nco_sign  out  N_CAR; all active values.
REQ-009 SHALL have ports: stream_gain_fraction  out  N_CAR x N_ANT x 16  active gain; ant_delay  out  N_ANT x 6; bypass_dpd  out  1; bypass_cfr  out  1; int_frac_delay_trig  out  1  one-cycle apply pulse.

Function
REQ-010 SHALL decode writes into shadow registers: 0x00+c NCO LSB; 0x10+c {sign=bit7, msb=bits6:0}; 0x20 {bypass_cfr=bit1, bypass_dpd=bit0}; 0x40+16c+a gain = bits15:0; 0x80+a delay = bits5:0.
REQ-011 SHALL ignore writes with c >= N_CAR, a >= N_ANT, or unmapped addresses; no shadow change.
REQ-012 SHALL accept shadow writes every cycle regardless of FSM state.
REQ-013 SHALL implement FSM states IDLE, ARMED, APPLY, RAMP.
REQ-014 IDLE: commit_req -> ARMED next cycle; sync_pulse coincident with commit_req SHALL NOT apply; wait for a later sync_pulse.
REQ-015 ARMED: sync_pulse -> APPLY next cycle.
REQ-016 APPLY (one cycle): SHALL copy shadow values registered before this cycle into active NCO, delay, bypass; SHALL load gain targets; SHALL assert int_frac_delay_trig for exactly this cycle; -> RAMP.
REQ-017 A write in the APPLY cycle SHALL update shadow only and take effect at the next commit.
REQ-018 RAMP: each active gain SHALL move toward its target by min(|target-active|, RAMP_STEP) per cycle, unsigned 16-bit, no overshoot or wrap.
REQ-019 RAMP SHALL exit to IDLE in the cycle after all gains equal targets, asserting commit_ack for that one cycle; RAMP with all gains already equal lasts one cycle.
REQ-020 busy SHALL be high in ARMED, APPLY, RAMP; low in IDLE.
REQ-021 commit_req when not IDLE SHALL be ignored and set commit_overrun; clr_flags clears it; simultaneous set and clear SHALL leave it set.
REQ-022 Outputs SHALL be registered; latency from the sync_pulse cycle to updated active NCO/delay/bypass SHALL be 2 clocks.

Reset
REQ-023 rst_n low SHALL immediately clear all shadow, active and target registers to 0, FSM to IDLE, busy, commit_ack, int_frac_delay_trig, commit_overrun to 0.
REQ-024 Reset asserted mid-commit SHALL abandon the commit; no commit_ack after release.
REQ-025 First commit after reset release SHALL behave identically to any other.

Configuration
REQ-026 Macro JB_DL_DFE_GAIN_RAMP_EN defined: RAMP state and ramp logic compiled in per REQ-018/019.
REQ-027 Macro undefined: APPLY SHALL load gains directly into active with other fields, go to IDLE with commit_ack in the following cycle; RAMP_STEP unused.

Verification
REQ-028 Write 0x00=0x12345678, 0x10=0xFF, commit_req, sync_pulse 5 cycles later -> car_nco_lsb[0]=0x12345678, msb=0x7F, sign=1 two clocks after sync_pulse; int_frac_delay_trig one pulse.
REQ-029 Ramp on: gain 0x40 = 0x0480 from 0, commit+sync -> active gain 0x0100,0x0200,0x0300,0x0400,0x0480 on successive cycles, then commit_ack; ramp off: 0x0480 at apply.
REQ-030 commit_req during ARMED -> commit_overrun=1, single commit completes; clr_flags -> 0.
REQ-031 N_CAR=2: write 0x02 and 0x91 with N_ANT=1 -> no output change after commit.
REQ-032 commit_req and sync_pulse same cycle in IDLE -> no apply until next sync_pulse.
REQ-033 rst_n low during RAMP -> all outputs 0 asynchronously, no commit_ack after release.
